// File: rtl/accelerator_avalon_bridge.sv
// accelerator_avalon_bridge: Avalon-MM slave register file plus waitrequest-aware
// Avalon-MM master that turns CNN core word requests into byte-addressed bus cycles.
module accelerator_avalon_bridge #(
    parameter int DATA_WIDTH      = 16,
    parameter int CORE_ADDR_WIDTH = 32,
    parameter int M_ADDR_WIDTH    = 18,
    parameter int BYTES_PER_WORD  = 4
) (
    input  logic                       AVS_Clk,
    input  logic                       AVS_Reset,
    input  logic [3:0]                 AVS_s0_adress,
    input  logic                       AVS_s0_read,
    input  logic                       AVS_s0_write,
    input  logic                       AVS_s0_chipselect,
    input  logic [31:0]                AVS_s0_writedata,
    output logic [31:0]                AVS_s0_readdata,
    output logic [M_ADDR_WIDTH-1:0]    AVS_m0_adress,
    output logic                       AVS_m0_read,
    output logic                       AVS_m0_write,
    output logic [31:0]                AVS_m0_writedata,
    output logic [3:0]                 AVS_m0_byteenable,
    input  logic [31:0]                AVS_m0_readdata,
    input  logic                       AVS_m0_waitrequest,
    input  logic                       AVS_Counduit_Start,
    input  logic                       AVS_Counduit_Same_W,
    input  logic                       AVS_Counduit_Finished_Ok,
    output logic                       AVS_Counduit_Finished,
    output logic                       AVS_Irq,
    output logic [31:0]                CORE_Cfg_Addr_Offset,
    output logic [31:0]                CORE_Cfg_If_Rows,
    output logic [31:0]                CORE_Cfg_If_Colums,
    output logic [31:0]                CORE_Cfg_If_Channels,
    output logic [31:0]                CORE_Cfg_Of_Rows,
    output logic [31:0]                CORE_Cfg_Of_Colums,
    output logic [31:0]                CORE_Cfg_W_Rows,
    output logic [31:0]                CORE_Cfg_W_Colums,
    output logic [31:0]                CORE_Cfg_W_Channels,
    output logic [31:0]                CORE_Cfg_Stride,
    output logic                       CORE_Start,
    output logic                       CORE_Finished_Ok,
    output logic                       CORE_Same_W,
    input  logic                       CORE_Finished,
    input  logic                       CORE_Req_Valid,
    input  logic                       CORE_Req_We,
    input  logic [CORE_ADDR_WIDTH-1:0] CORE_Req_Addr,
    input  logic [DATA_WIDTH-1:0]      CORE_Req_Wdata,
    output logic                       CORE_Req_Ready,
    output logic                       CORE_Rsp_Valid,
    output logic [DATA_WIDTH-1:0]      CORE_Rsp_Data
);
    localparam int SHIFT = $clog2(BYTES_PER_WORD);
    localparam logic [31:0] CFG_RST [10] = '{32'd9, 32'd8, 32'd8, 32'd3, 32'd7,
                                             32'd5, 32'd2, 32'd4, 32'd3, 32'd1};

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state;

    logic [31:0] cfg [10];
    logic [31:0] base_addr, txn_count;
    logic        same_w, irq_en, busy, done, start_q, ok_q;
    logic        sw_wr, start_req, take_start, clr_req, cfg_wr, xfer_done;
    logic        unused_rdata;

    assign unused_rdata = ^AVS_m0_readdata[31:DATA_WIDTH];

    assign {CORE_Cfg_Addr_Offset, CORE_Cfg_If_Rows, CORE_Cfg_If_Colums, CORE_Cfg_If_Channels,
            CORE_Cfg_Of_Rows, CORE_Cfg_Of_Colums, CORE_Cfg_W_Rows, CORE_Cfg_W_Colums,
            CORE_Cfg_W_Channels, CORE_Cfg_Stride} =
           {cfg[0], cfg[1], cfg[2], cfg[3], cfg[4], cfg[5], cfg[6], cfg[7], cfg[8], cfg[9]};

    assign AVS_m0_byteenable     = 4'hF;
    assign AVS_Counduit_Finished = done;
    assign AVS_Irq               = done & irq_en;
    assign CORE_Same_W           = same_w | AVS_Counduit_Same_W;

    assign sw_wr      = AVS_s0_chipselect & AVS_s0_write;
    assign start_req  = (sw_wr & (AVS_s0_adress == 4'd0) & AVS_s0_writedata[0]) |
                        (AVS_Counduit_Start & ~start_q);
    assign take_start = start_req & ~busy & ~CORE_Finished;
    assign clr_req    = (sw_wr & (AVS_s0_adress == 4'd1) & AVS_s0_writedata[1]) |
                        (AVS_Counduit_Finished_Ok & ~ok_q);
    assign cfg_wr     = sw_wr & ~busy;
    assign xfer_done  = (state != IDLE) & ~AVS_m0_waitrequest;

    assign AVS_s0_readdata = !(AVS_s0_chipselect && AVS_s0_read) ? 32'd0 :
                             AVS_s0_adress == 4'd0  ? {29'd0, irq_en, same_w, 1'b0} :
                             AVS_s0_adress == 4'd1  ? {30'd0, done, busy} :
                             AVS_s0_adress <= 4'd11 ? cfg[AVS_s0_adress - 4'd2] :
                             AVS_s0_adress == 4'd12 ? base_addr :
                             AVS_s0_adress == 4'd13 ? txn_count : 32'd0;

    always_ff @(posedge AVS_Clk or negedge AVS_Reset) begin
        if (!AVS_Reset) begin
            for (int i = 0; i < 10; i++) cfg[i] <= CFG_RST[i];
            base_addr        <= 32'd0;
            txn_count        <= 32'd0;
            same_w           <= 1'b0;
            irq_en           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            start_q          <= 1'b0;
            ok_q             <= 1'b0;
            CORE_Start       <= 1'b0;
            CORE_Finished_Ok <= 1'b0;
        end else begin
            start_q          <= AVS_Counduit_Start;
            ok_q             <= AVS_Counduit_Finished_Ok;
            CORE_Start       <= take_start;
            CORE_Finished_Ok <= clr_req & done & ~CORE_Finished;
            if (sw_wr && AVS_s0_adress == 4'd0) begin
                same_w <= AVS_s0_writedata[1];
                irq_en <= AVS_s0_writedata[2];
            end
            for (int i = 0; i < 10; i++)
                if (cfg_wr && AVS_s0_adress == 4'(i + 2)) cfg[i] <= AVS_s0_writedata;
            if (cfg_wr && AVS_s0_adress == 4'd12) base_addr <= AVS_s0_writedata;
            busy      <= CORE_Finished ? 1'b0 : take_start ? 1'b1 : busy;
            // a completion in the same cycle as a clear keeps done set
            done      <= CORE_Finished | (done & ~take_start & ~clr_req);
            txn_count <= take_start ? 32'd0 : txn_count + 32'(xfer_done);
        end
    end

    always_ff @(posedge AVS_Clk or negedge AVS_Reset) begin
        if (!AVS_Reset) begin
            state            <= IDLE;
            AVS_m0_adress    <= '0;
            AVS_m0_read      <= 1'b0;
            AVS_m0_write     <= 1'b0;
            AVS_m0_writedata <= 32'd0;
            CORE_Req_Ready   <= 1'b0;
            CORE_Rsp_Valid   <= 1'b0;
            CORE_Rsp_Data    <= '0;
        end else begin
            CORE_Rsp_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    CORE_Req_Ready <= 1'b1;
                    if (CORE_Req_Ready && CORE_Req_Valid) begin
                        AVS_m0_adress    <= M_ADDR_WIDTH'(base_addr + (32'(CORE_Req_Addr) << SHIFT));
                        AVS_m0_writedata <= 32'($signed(CORE_Req_Wdata));
                        AVS_m0_read      <= ~CORE_Req_We;
                        AVS_m0_write     <= CORE_Req_We;
                        CORE_Req_Ready   <= 1'b0;
                        state            <= CORE_Req_We ? WR : RD;
                    end
                end
                RD: if (!AVS_m0_waitrequest) begin
                    AVS_m0_read    <= 1'b0;
                    CORE_Rsp_Data  <= AVS_m0_readdata[DATA_WIDTH-1:0];
                    CORE_Rsp_Valid <= 1'b1;
                    CORE_Req_Ready <= 1'b1;
                    state          <= IDLE;
                end
                WR: if (!AVS_m0_waitrequest) begin
                    AVS_m0_write   <= 1'b0;
                    CORE_Req_Ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
